tff_toggle_sequencer: RTL

//  Controller that drives a bank of N T flip-flops to a commanded target pattern.

---
 rtl/tff_toggle_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/tff_toggle_sequencer.sv
// Steers a bank of N T flip-flops to a commanded pattern: one toggle per step, LSB
// first, then verifies the live Q value and retries a bounded number of times.
module tff_toggle_sequencer #(
    parameter int N         = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_target,
    input  logic         cmd_abort,
    input  logic [N-1:0] q_in,
    output logic [N-1:0] t_out,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [7:0]   toggle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_TOGGLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] target_q;
    logic [N-1:0] mask_q;
    logic [N-1:0] diff;
    logic [N-1:0] step_src;
    logic [N-1:0] step_bit;
    logic [2:0]   retry_q;
    logic         accept;
    logic         abort_hit;

    assign cmd_ready = (state == S_IDLE) && rst;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign abort_hit = cmd_abort && (state inside {S_CALC, S_TOGGLE, S_WAIT, S_CHECK});

    // The pulse is loaded on entry to TOGGLE so the bank toggles on the edge that
    // ends TOGGLE; the first step comes from the fresh diff, later ones from mask_q.
    assign diff     = q_in ^ target_q;
    assign step_src = (state == S_CALC) ? diff : mask_q;
    assign step_bit = step_src & (-step_src);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: every sequential assignment is non-blocking so all registers
            // sample the same pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        if (abort_hit) begin
            state_nxt = S_DONE;
        end else begin
            case (state)
                S_IDLE:   if (accept) state_nxt = S_CALC;
                S_CALC:   state_nxt = (diff == '0) ? S_CHECK : S_TOGGLE;
                S_TOGGLE: state_nxt = S_WAIT;
                S_WAIT:   state_nxt = (mask_q != '0) ? S_TOGGLE : S_CHECK;
                S_CHECK: begin
                    if (q_in == target_q)          state_nxt = S_DONE;
                    else if (retry_q < RETRY_LIMIT) state_nxt = S_CALC;
                    else                            state_nxt = S_DONE;
                end
                S_DONE:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_q   <= '0;
            mask_q     <= '0;
            t_out      <= '0;
            retry_q    <= '0;
            err        <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            t_out <= '0;
            if (accept) begin
                target_q   <= cmd_target;
                mask_q     <= '0;
                retry_q    <= '0;
                err        <= 1'b0;
                toggle_cnt <= '0;
            end
            if (state_nxt == S_TOGGLE) begin
                t_out  <= step_bit;
                mask_q <= step_src & ~step_bit;
                if (toggle_cnt != 8'hFF) toggle_cnt <= toggle_cnt + 8'd1;
            end
            if ((state == S_CHECK) && (state_nxt == S_CALC)) begin
                retry_q <= retry_q + 3'd1;
            end
            // Abort always flags an error; otherwise only CHECK can reach DONE.
            if ((state_nxt == S_DONE) && (state != S_DONE)) begin
                err <= abort_hit || (q_in != target_q);
            end
        end
    end

endmodule
